// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_pkg
//  Brief    : Shared types and constants for the bit-serial adder controller.
//  Revision : 1.0
// ============================================================================
package serial_add_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fadd_cell.sv
`default_nettype none
// ============================================================================
//  Module   : fadd_cell
//  Brief    : 1-bit full adder built from two half-adder stages.
//  Revision : 1.0
// ============================================================================
module fadd_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = a ^ b;
    assign w_c1 = a & b;
    assign s    = w_s1 ^ ci;
    assign w_c2 = w_s1 & ci;
    assign co   = w_c1 | w_c2;

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Brief    : Bit-serial adder (LSB first, one bit per cycle) with
//             valid/ready handshakes on operands and result.
//  Revision : 1.0
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_co;

    fadd_cell u_fadd (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handoff (DONE -> IDLE) and acceptance can never share an edge because
    // in_ready is only asserted in IDLE.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so the first bit lands in bit 0 after WIDTH shifts.
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    if (r_cnt != c_LAST) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Brief    : Randomized self-checking bench for serial_add_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, wait for result, hold in DONE, hand off.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input int hold, input bit pulse);
        logic [W:0] exp_v;
        int lat;
        exp_v = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; a = ta; b = tb_v; cin = tc;
        step();
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("in_ready_run", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (lat < 4 * W) begin
            if (pulse && lat == 3) begin
                in_valid = 1'b1; a = W'(8'h11);
            end else begin
                in_valid = 1'b0;
            end
            step();
            lat++;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        chk("latency", lat, W);
        chk("sum", {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, exp_v[W-1:0]});
        chk("cout", {31'd0, cout}, {31'd0, exp_v[W]});
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, exp_v[W-1:0]});
            chk("hold_cout", {31'd0, cout}, {31'd0, exp_v[W]});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        // A request presented during the handoff edge must not be taken.
        out_ready = 1'b1; in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
        step();
        out_ready = 1'b0;
        chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
        chk("handoff_busy", {31'd0, busy}, 32'd0);
        chk("handoff_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_sum"}, {{(32-W){1'b0}}, sum}, 32'd0);
        chk({tag, "_cout"}, {31'd0, cout}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) step();
        reset_check("reset");
        rst = 1'b0;
        step();

        run_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
        run_op(8'h30, 8'h0C, 1'b0, 5, 1'b0);
        run_op(8'h42, 8'h27, 1'b1, 0, 1'b1);

        // Abort an operation mid-run at counter == 3.
        in_valid = 1'b1; a = 8'hC3; b = 8'h7E; cin = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_check("abort");
        run_op(8'h9D, 8'h64, 1'b1, 2, 1'b0);

        for (int k = 0; k < 30; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning operand width in bits; legal range is WIDTH >= 2.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 Port in_valid SHALL be an input, 1 bit: the operand request is valid.
REQ-005 Port in_ready SHALL be an output, 1 bit: the block can accept operands.
REQ-006 Ports a and b SHALL be inputs, WIDTH bits each: the operands.
REQ-007 Port cin SHALL be an input, 1 bit: the carry-in.
REQ-008 Port out_valid SHALL be an output, 1 bit: the result is valid.
REQ-009 Port out_ready SHALL be an input, 1 bit: the consumer accepts the result.
REQ-010 Port sum SHALL be an output, WIDTH bits: the result, equal to (a+b+cin) mod 2^WIDTH.
REQ-011 Port cout SHALL be an output, 1 bit: the carry-out of the WIDTH-bit addition.
REQ-012 Port busy SHALL be an output, 1 bit: high while the FSM is in RUN.

Function
REQ-013 The block SHALL compute the sum bit-serially, LSB first, one bit per cycle, using a single 1-bit full-adder cell.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1, and out_valid and busy SHALL be 0.
REQ-016 When in IDLE with in_valid=1, the block SHALL, on the same edge, latch a and b into operand shift registers, set the carry register to cin, clear the bit counter, clear the sum register, and go to RUN.
REQ-017 In RUN, each cycle SHALL:
  - add operand LSBs plus the carry;
  - shift the sum bit into the sum register from the MSB side;
  - update the carry register;
  - shift both operand registers right;
  - increment the counter.
REQ-018 RUN SHALL last exactly WIDTH cycles, exiting to DONE on the edge where counter == WIDTH-1.
REQ-019 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap inside RUN.
REQ-020 In DONE:
  - out_valid SHALL be 1;
  - sum and cout SHALL hold the final result;
  - in_ready and busy SHALL be 0.
REQ-021 Latency: with operands accepted on edge T, out_valid SHALL first be 1 in the cycle after edge T+WIDTH.
REQ-022 In DONE with out_ready=0, sum, cout and out_valid SHALL remain stable indefinitely.
REQ-023 In DONE with out_ready=1, the block SHALL return to IDLE on that edge.
REQ-024 A new request SHALL NOT be accepted in the same cycle as a result handoff.
REQ-025 in_valid, a, b and cin SHALL be ignored outside IDLE; operands SHALL be sampled only at acceptance.
REQ-026 sum and cout SHALL be registered outputs.
REQ-027 sum and cout SHALL be undefined-free (holding the previous or partial value) while out_valid=0; consumers SHALL NOT use them in that state.

Reset
REQ-028 When rst=1 at a rising edge, the FSM SHALL go to IDLE, and the counter, carry, operand and sum registers SHALL be cleared to 0.
REQ-029 After reset, output values SHALL be: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
REQ-030 Reset in RUN or DONE SHALL abort and discard the operation with no output handshake.
REQ-031 rst SHALL take priority over in_valid and out_ready.

Structure
REQ-032 The shared package serial_add_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-033 The combinational bit cell SHALL be the sub-module fadd_cell (inputs a, b, ci; outputs s, co), built from two half-adder stages plus an OR of the carries.
REQ-034 fadd_cell SHALL be instantiated exactly once.

Verification
REQ-035 Scenario: WIDTH=8, a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, out_valid in the cycle after edge T+8.
REQ-036 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
REQ-037 Scenario: a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-038 Scenario: result 0x3C, out_ready held 0 for 5 cycles in DONE -> sum, cout and out_valid stable; in_ready=0; returns to IDLE on the edge where out_ready=1.
REQ-039 Scenario: in_valid pulsed with a=0x11 in the middle of RUN -> ignored; the original result is delivered unchanged.
REQ-040 Scenario: rst asserted at counter=3 in RUN -> next cycle in_ready=1, busy=0, out_valid=0, sum=0, cout=0; a new request then completes correctly.
